// File: rtl/act_lut_stream.sv
// act_lut_stream: pipelined streaming activation unit (SiLU / sigmoid / ReLU / identity).
//
// DIM signed fixed-point lanes per beat move through a valid/ready pipeline. All stages
// advance together on en = !out_valid || out_ready, so a stalled output freezes the whole
// pipe and nothing is ever dropped. A sigmoid table built at elaboration is addressed from
// the clamped input; the final stage applies the per-beat activation.
//
// Stages (default build): S1 clamp + index, S2 table read, S3 activation -> out_vec.
// Optional macro ACT_LUT_INTERP_EN: S2 also reads the next table entry and an extra stage
// linearly interpolates between the two, giving latency/capacity 4 instead of 3.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset; flushes every in-flight beat
//   in_valid   input beat valid
//   in_ready   unit can accept a beat this cycle (combinational from en)
//   in_mode    activation: 0 SiLU, 1 sigmoid, 2 ReLU, 3 identity
//   in_vec     packed signed lanes, lane j at [j*WIDTH +: WIDTH]
//   out_valid  output beat valid
//   out_ready  downstream accepts a beat
//   out_vec    packed signed results
module act_lut_stream #(
    parameter int          DIM      = 4,
    parameter int          WIDTH    = 16,
    parameter int          FRAC     = 8,
    parameter int          LUT_SIZE = 1024,
    parameter int          X_MIN_Q  = -(8 << FRAC),
    parameter int          X_MAX_Q  = (8 << FRAC),
    parameter int unsigned SATURATE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [DIM*WIDTH-1:0] in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIM*WIDTH-1:0] out_vec
);

    localparam int RANGE_Q = X_MAX_Q - X_MIN_Q;
    localparam int IDX_W   = $clog2(LUT_SIZE);
    localparam int PW      = 2 * WIDTH + 1;
    localparam int VW      = DIM * WIDTH;
    localparam int IW      = DIM * IDX_W;

    localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) << (WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) << (WIDTH - 1));

    localparam logic [1:0] MODE_SILU = 2'd0;
    localparam logic [1:0] MODE_SIG  = 2'd1;
    localparam logic [1:0] MODE_RELU = 2'd2;
    localparam logic [1:0] MODE_ID   = 2'd3;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Table entry i: round-half-away-from-zero of sigmoid at the sample point, scaled by
    // 2^FRAC. The value is never negative, so adding 0.5 and truncating is enough.
    function automatic logic [WIDTH-1:0] lut_entry(input int i);
        longint sv;
        real    scale;
        real    xr;
        real    sg;
        scale = real'(longint'(1) <<< FRAC);
        sv    = longint'(X_MIN_Q) + (longint'(i) * longint'(RANGE_Q)) / longint'(LUT_SIZE - 1);
        xr    = real'(sv) / scale;
        sg    = scale / (1.0 + $exp(-xr));
        return WIDTH'($rtoi(sg + 0.5));
    endfunction

    function automatic longint clamp_x(input logic signed [WIDTH-1:0] x);
        longint xc;
        xc = longint'(x);
        if (xc < longint'(X_MIN_Q)) begin
            xc = longint'(X_MIN_Q);
        end else if (xc > longint'(X_MAX_Q)) begin
            xc = longint'(X_MAX_Q);
        end
        return xc;
    endfunction

    function automatic logic [IDX_W-1:0] lut_index(input logic signed [WIDTH-1:0] x);
        longint idx;
        idx = ((clamp_x(x) - longint'(X_MIN_Q)) * longint'(LUT_SIZE - 1)) / longint'(RANGE_Q);
        if (idx < 0) begin
            idx = '0;
        end else if (idx > longint'(LUT_SIZE - 1)) begin
            idx = longint'(LUT_SIZE - 1);
        end
        return IDX_W'(idx);
    endfunction

`ifdef ACT_LUT_INTERP_EN
    // Fractional position between idx and idx+1 as a 16-bit fraction.
    function automatic logic [15:0] lut_frac(input logic signed [WIDTH-1:0] x);
        longint num;
        num = (clamp_x(x) - longint'(X_MIN_Q)) * longint'(LUT_SIZE - 1);
        return 16'(((num % longint'(RANGE_Q)) <<< 16) / longint'(RANGE_Q));
    endfunction

    function automatic logic [IDX_W-1:0] lut_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(LUT_SIZE - 1)) ? idx : idx + IDX_W'(1);
    endfunction

    function automatic logic [WIDTH-1:0] interp(
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi,
        input logic [15:0]      fw
    );
        logic signed [WIDTH:0]    diff;
        logic signed [WIDTH+17:0] step;
        diff = $signed({hi[WIDTH-1], hi}) - $signed({lo[WIDTH-1], lo});
        step = (WIDTH+18)'(diff) * (WIDTH+18)'($signed({2'b00, fw}));
        return lo + WIDTH'(step >>> 16);
    endfunction
`endif

    function automatic logic [WIDTH-1:0] act_lane(
        input logic [1:0]       mode,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] sig
    );
        logic signed [PW-1:0] prod;
        logic        [PW-1:0] mag;
        logic signed [PW-1:0] res;
        logic        [WIDTH-1:0] y;
        prod = PW'($signed(x)) * PW'($signed(sig));
        // Round the magnitude so negative products round away from zero symmetrically.
        mag  = prod[PW-1] ? -prod : prod;
        mag  = (mag + (PW'(1) << (FRAC - 1))) >> FRAC;
        res  = prod[PW-1] ? -$signed(mag) : $signed(mag);
        if (SATURATE != 0) begin
            if (res > SAT_MAX) begin
                res = SAT_MAX;
            end else if (res < SAT_MIN) begin
                res = SAT_MIN;
            end
        end
        y = res[WIDTH-1:0];
        case (mode)
            MODE_SILU: return y;
            MODE_SIG:  return sig;
            MODE_RELU: return x[WIDTH-1] ? '0 : x;
            MODE_ID:   return x;
            default:   return x;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Sigmoid table, fully determined at elaboration
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] lut [LUT_SIZE];

    for (genvar gi = 0; gi < LUT_SIZE; gi++) begin : g_lut
        assign lut[gi] = lut_entry(gi);
    end

    // ------------------------------------------------------------------
    // Global advance
    // ------------------------------------------------------------------
    logic en;
    logic out_valid_q, out_valid_d;
    logic [VW-1:0] out_vec_q, out_vec_d;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;

    // ------------------------------------------------------------------
    // S1: clamp and index
    // ------------------------------------------------------------------
    logic          s1_valid_q, s1_valid_d;
    logic [1:0]    s1_mode_q, s1_mode_d;
    logic [VW-1:0] s1_x_q, s1_x_d;
    logic [IW-1:0] s1_idx_q, s1_idx_d;
`ifdef ACT_LUT_INTERP_EN
    logic [DIM*16-1:0] s1_frac_q, s1_frac_d;
`endif

    always_comb begin
        s1_valid_d = in_valid;
        s1_mode_d  = in_mode;
        s1_x_d     = in_vec;
        s1_idx_d   = '0;
        for (int j = 0; j < DIM; j++) begin
            s1_idx_d[j*IDX_W +: IDX_W] = lut_index(in_vec[j*WIDTH +: WIDTH]);
        end
`ifdef ACT_LUT_INTERP_EN
        s1_frac_d = '0;
        for (int j = 0; j < DIM; j++) begin
            s1_frac_d[j*16 +: 16] = lut_frac(in_vec[j*WIDTH +: WIDTH]);
        end
`endif
    end

    // ------------------------------------------------------------------
    // S2: table read; x and mode ride alongside
    // ------------------------------------------------------------------
    logic          s2_valid_q, s2_valid_d;
    logic [1:0]    s2_mode_q, s2_mode_d;
    logic [VW-1:0] s2_x_q, s2_x_d;
    logic [VW-1:0] s2_sig_q, s2_sig_d;
`ifdef ACT_LUT_INTERP_EN
    logic [VW-1:0]     s2_hi_q, s2_hi_d;
    logic [DIM*16-1:0] s2_frac_q, s2_frac_d;
`endif

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_mode_d  = s1_mode_q;
        s2_x_d     = s1_x_q;
        s2_sig_d   = '0;
        for (int j = 0; j < DIM; j++) begin
            s2_sig_d[j*WIDTH +: WIDTH] = lut[s1_idx_q[j*IDX_W +: IDX_W]];
        end
`ifdef ACT_LUT_INTERP_EN
        s2_frac_d = s1_frac_q;
        s2_hi_d   = '0;
        for (int j = 0; j < DIM; j++) begin
            s2_hi_d[j*WIDTH +: WIDTH] = lut[lut_next(s1_idx_q[j*IDX_W +: IDX_W])];
        end
`endif
    end

    // ------------------------------------------------------------------
    // Source feeding the activation stage (S2 directly, or the interpolation stage)
    // ------------------------------------------------------------------
    logic          cv_valid;
    logic [1:0]    cv_mode;
    logic [VW-1:0] cv_x;
    logic [VW-1:0] cv_sig;

`ifdef ACT_LUT_INTERP_EN
    logic          si_valid_q, si_valid_d;
    logic [1:0]    si_mode_q, si_mode_d;
    logic [VW-1:0] si_x_q, si_x_d;
    logic [VW-1:0] si_sig_q, si_sig_d;

    always_comb begin
        si_valid_d = s2_valid_q;
        si_mode_d  = s2_mode_q;
        si_x_d     = s2_x_q;
        si_sig_d   = '0;
        for (int j = 0; j < DIM; j++) begin
            si_sig_d[j*WIDTH +: WIDTH] = interp(s2_sig_q[j*WIDTH +: WIDTH],
                                                s2_hi_q[j*WIDTH +: WIDTH],
                                                s2_frac_q[j*16 +: 16]);
        end
    end

    assign cv_valid = si_valid_q;
    assign cv_mode  = si_mode_q;
    assign cv_x     = si_x_q;
    assign cv_sig   = si_sig_q;
`else
    assign cv_valid = s2_valid_q;
    assign cv_mode  = s2_mode_q;
    assign cv_x     = s2_x_q;
    assign cv_sig   = s2_sig_q;
`endif

    // ------------------------------------------------------------------
    // S3: activation into out_vec
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = cv_valid;
        out_vec_d   = '0;
        for (int j = 0; j < DIM; j++) begin
            out_vec_d[j*WIDTH +: WIDTH] = act_lane(cv_mode, cv_x[j*WIDTH +: WIDTH],
                                                   cv_sig[j*WIDTH +: WIDTH]);
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers. Data fields load only with a valid beat so bubbles leave the
    // last real result in place.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= '0;
            s1_x_q      <= '0;
            s1_idx_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= '0;
            s2_x_q      <= '0;
            s2_sig_q    <= '0;
`ifdef ACT_LUT_INTERP_EN
            s1_frac_q   <= '0;
            s2_hi_q     <= '0;
            s2_frac_q   <= '0;
            si_valid_q  <= 1'b0;
            si_mode_q   <= '0;
            si_x_q      <= '0;
            si_sig_q    <= '0;
`endif
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
        end else if (en) begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            if (s1_valid_d) begin
                s1_mode_q <= s1_mode_d;
                s1_x_q    <= s1_x_d;
                s1_idx_q  <= s1_idx_d;
`ifdef ACT_LUT_INTERP_EN
                s1_frac_q <= s1_frac_d;
`endif
            end
            if (s2_valid_d) begin
                s2_mode_q <= s2_mode_d;
                s2_x_q    <= s2_x_d;
                s2_sig_q  <= s2_sig_d;
`ifdef ACT_LUT_INTERP_EN
                s2_hi_q   <= s2_hi_d;
                s2_frac_q <= s2_frac_d;
`endif
            end
`ifdef ACT_LUT_INTERP_EN
            si_valid_q <= si_valid_d;
            if (si_valid_d) begin
                si_mode_q <= si_mode_d;
                si_x_q    <= si_x_d;
                si_sig_q  <= si_sig_d;
            end
`endif
            if (out_valid_d) begin
                out_vec_q <= out_vec_d;
            end
        end
    end

endmodule
